// File: rtl/mw_add_seq.sv
// mw_add_seq: multi-word add/subtract sequencer for an external WIDTH-bit
// combinational adder. Operand words arrive LS word first; the adder's
// carry-out is chained into the next word's carry-in. Each sum word is
// registered behind a valid/ready output stage, one word per cycle.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   operand word handshake
//   in_a, in_b          operand words
//   in_last             most significant word of the operand
//   in_sub, in_cin      op select and carry-in, sampled on the first word only
//   add_x1/x2/cin       drive to the adder
//   add_s, add_cout     adder result
//   out_valid/out_ready result word handshake
//   out_sum, out_cout   result word and its carry-out
//   out_last            final word of the operation
//   out_ovf             signed overflow (meaningful with out_last)
//   out_trunc           operation closed at MAX_WORDS without in_last
//   out_words           word count within the operation, including this one
module mw_add_seq #(
    parameter int  WIDTH     = 32,
    parameter int  MAX_WORDS = 16,
    localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_x1,
    output logic [WIDTH-1:0] add_x2,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_trunc,
    output logic [CNT_W-1:0] out_words
);

    typedef enum logic {FIRST, CHAIN} state_t;

    state_t             state_q,     state_d;
    logic               carry_q,     carry_d;
    logic               sub_q,       sub_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_sum_q,   out_sum_d;
    logic               out_last_q,  out_last_d;
    logic               out_cout_q,  out_cout_d;
    logic               out_ovf_q,   out_ovf_d;
    logic               out_trunc_q, out_trunc_d;
    logic [CNT_W-1:0]   out_words_q, out_words_d;

    logic               accept;
    logic               is_first;
    logic               sub_sel;
    logic               close;
    logic [CNT_W-1:0]   cnt_inc;

    // Output register may be refilled in the same cycle it is drained,
    // so a stalled consumer is the only thing that blocks input.
    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // Op select and carry come from the live inputs on the first word and
    // from the captured state on every following word.
    assign is_first = (state_q == FIRST);
    assign sub_sel  = is_first ? in_sub : sub_q;
    assign add_x1   = in_a;
    assign add_x2   = in_b ^ {WIDTH{sub_sel}};
    assign add_cin  = is_first ? (in_sub | in_cin) : carry_q;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    // Force closure at MAX_WORDS so a missing in_last cannot run the count past its range.
    assign close    = in_last | (cnt_inc == CNT_W'(MAX_WORDS));

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        out_trunc_d = out_trunc_q;
        out_words_d = out_words_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_sum_d   = add_s;
            out_cout_d  = add_cout;
            out_words_d = cnt_inc;
            out_ovf_d   = (in_a[WIDTH-1] == add_x2[WIDTH-1]) &
                          (add_s[WIDTH-1] != in_a[WIDTH-1]);
            out_last_d  = close;
            out_trunc_d = close & ~in_last;
            if (close) begin
                state_d = FIRST;
                cnt_d   = '0;
                carry_d = 1'b0;
            end else begin
                state_d = CHAIN;
                cnt_d   = cnt_inc;
                carry_d = add_cout;
                if (is_first) sub_d = in_sub;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FIRST;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_trunc_q <= 1'b0;
            out_words_q <= '0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
            out_trunc_q <= out_trunc_d;
            out_words_q <= out_words_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
    assign out_trunc = out_trunc_q;
    assign out_words = out_words_q;

endmodule

// File: tb/tb_mw_add_seq.sv
// Scoreboard bench for mw_add_seq with a combinational adder model attached.
module tb_mw_add_seq;
    localparam int W  = 32;
    localparam int MW = 16;
    localparam int CW = $clog2(MW + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_ready;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic          in_last = 1'b0, in_sub = 1'b0, in_cin = 1'b0;
    logic [W-1:0]  add_x1, add_x2, add_s;
    logic          add_cin, add_cout;
    logic          out_valid, out_ready = 1'b1;
    logic [W-1:0]  out_sum;
    logic          out_last, out_cout, out_ovf, out_trunc;
    logic [CW-1:0] out_words;

    mw_add_seq #(.WIDTH(W), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_sub(in_sub), .in_cin(in_cin),
        .add_x1(add_x1), .add_x2(add_x2), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_last(out_last), .out_cout(out_cout),
        .out_ovf(out_ovf), .out_trunc(out_trunc), .out_words(out_words)
    );

    // The attached adder
    assign {add_cout, add_s} = {1'b0, add_x1} + {1'b0, add_x2} + {{W{1'b0}}, add_cin};

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  sum;
        logic          cout;
        logic          last;
        logic          ovf;
        logic          trunc;
        logic [CW-1:0] words;
    } res_t;

    typedef struct {
        res_t m;      // reference model
        res_t g;      // hand-written constant, when has_g
        bit   has_g;
    } item_t;

    int    n_cmp = 0;
    int    n_err = 0;
    item_t sb[$];
    item_t pend_item;
    bit    pend_v = 0;
    bit    gold_v = 0;
    res_t  gold_next;
    bit    mon_en = 0;
    int    stall_cnt = 0;
    bit    rand_rdy = 0;
    bit    rand_gap = 0;

    // Reference model: one operation is a wide number streamed LS word first.
    bit m_first = 1;
    bit m_sub   = 0;
    bit m_carry = 0;
    int m_cnt   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic res_t predict(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input bit last, input bit sub, input bit cin);
        res_t   r;
        bit     s, c, close;
        logic [W-1:0] x2;
        logic [63:0]  u;
        longint sr;
        s  = m_first ? sub : m_sub;
        c  = m_first ? (sub ? 1'b1 : cin) : m_carry;
        x2 = s ? ~b : b;
        u  = {32'b0, a} + {32'b0, x2} + 64'(c);
        sr = longint'($signed(a)) + longint'($signed(x2)) + longint'(c);
        close   = last || (m_cnt + 1 == MW);
        r.sum   = u[W-1:0];
        r.cout  = u[W];
        r.ovf   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.last  = close;
        r.trunc = close && !last;
        r.words = CW'(m_cnt + 1);
        if (close) begin
            m_first = 1; m_cnt = 0; m_carry = 0;
        end else begin
            if (m_first) m_sub = s;
            m_first = 0; m_cnt = m_cnt + 1; m_carry = u[W];
        end
        return r;
    endfunction

    function automatic res_t mk(input logic [W-1:0] sum, input bit cout, input bit last,
                                input bit ovf, input bit trunc, input int words);
        res_t r;
        r.sum = sum; r.cout = cout; r.last = last; r.ovf = ovf; r.trunc = trunc;
        r.words = CW'(words);
        return r;
    endfunction

    task automatic drive_rdy();
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else begin
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            drive_rdy();
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit last, input bit sub, input bit cin);
        int t = 0;
        bit done = 0;
        if (rand_gap && $urandom_range(0, 3) == 0) idle(1);
        while (!done) begin
            @(posedge clk); #1;
            drive_rdy();
            in_valid = 1'b1; in_a = a; in_b = b; in_last = last; in_sub = sub; in_cin = cin;
            #1;
            if (in_ready) begin
                pend_item.m     = predict(a, b, last, sub, cin);
                pend_item.g     = gold_next;
                pend_item.has_g = gold_v;
                gold_v = 0;
                pend_v = 1;
                done   = 1;
            end else if (++t > 50) begin
                n_cmp++; n_err++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", t);
                done = 1;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        pend_v = 0;
        m_first = 1; m_sub = 0; m_carry = 0; m_cnt = 0;
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // An accepted word becomes visible at the DUT output after this edge.
    always @(posedge clk) begin
        if (pend_v) begin
            sb.push_back(pend_item);
            pend_v = 0;
        end
    end

    // Monitor: compares the presented word against the scoreboard head every
    // cycle it is valid (so a stall must hold it), pops on handshake.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            item_t it;
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            if (out_valid && sb.size() != 0) begin
                it = sb[0];
                chk("out_sum",   64'(out_sum),   64'(it.m.sum));
                chk("out_cout",  64'(out_cout),  64'(it.m.cout));
                chk("out_last",  64'(out_last),  64'(it.m.last));
                chk("out_ovf",   64'(out_ovf),   64'(it.m.ovf));
                chk("out_trunc", 64'(out_trunc), 64'(it.m.trunc));
                chk("out_words", 64'(out_words), 64'(it.m.words));
                if (it.has_g)
                    chk("directed_result", 64'({out_sum, out_cout, out_last, out_ovf, out_trunc, out_words}),
                        64'(it.g));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        int len;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum",   64'(out_sum),   64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_out_cout",  64'(out_cout),  64'd0);
        chk("rst_out_ovf",   64'(out_ovf),   64'd0);
        chk("rst_out_trunc", 64'(out_trunc), 64'd0);
        chk("rst_out_words", 64'(out_words), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        mon_en = 1;

        // 2-word add with carry between words
        gold_next = mk(32'h0, 1, 0, 0, 0, 1); gold_v = 1;
        send(32'hFFFF_FFFF, 32'h1, 0, 0, 0);
        gold_next = mk(32'h2, 0, 1, 0, 0, 2); gold_v = 1;
        send(32'h1, 32'h0, 1, 0, 0);
        // 1-word subtract with borrow
        gold_next = mk(32'hFFFF_FFFE, 0, 1, 0, 0, 1); gold_v = 1;
        send(32'd5, 32'd7, 1, 1, 0);
        // signed overflow and plain carry-out
        gold_next = mk(32'h8000_0000, 0, 1, 1, 0, 1); gold_v = 1;
        send(32'h7FFF_FFFF, 32'h1, 1, 0, 0);
        gold_next = mk(32'h0, 1, 1, 0, 0, 1); gold_v = 1;
        send(32'hFFFF_FFFF, 32'h1, 1, 0, 0);

        // 4-word add with a 3-cycle output stall in the middle
        idle(2);
        gold_next = mk(32'h0, 1, 0, 0, 0, 1); gold_v = 1;
        send(32'hFFFF_FFFF, 32'h1, 0, 0, 0);
        gold_next = mk(32'h0, 1, 0, 0, 0, 2); gold_v = 1;
        send(32'hFFFF_FFFF, 32'h0, 0, 0, 0);
        stall_cnt = 3;
        gold_next = mk(32'h0, 1, 0, 0, 0, 3); gold_v = 1;
        send(32'hFFFF_FFFF, 32'h0, 0, 1, 0);
        gold_next = mk(32'h0, 1, 1, 0, 0, 4); gold_v = 1;
        send(32'hFFFF_FFFF, 32'h0, 1, 0, 0);

        // 17 words with no in_last: forced close at 16, word 17 starts afresh
        for (int i = 0; i < MW; i++) begin
            if (i == MW - 1) begin
                gold_next = mk(32'h1, 1, 1, 0, 1, MW); gold_v = 1;
            end
            send(32'hFFFF_FFFF, 32'h1, 0, 0, 0);
        end
        gold_next = mk(32'h1, 0, 1, 0, 0, 1); gold_v = 1;
        send(32'h0, 32'h0, 1, 0, 1);

        // reset in the middle of a 4-word subtract
        send(32'd10, 32'd3, 0, 1, 0);
        send(32'd0, 32'd0, 0, 1, 0);
        do_reset();
        @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        gold_next = mk(32'd7, 0, 1, 0, 0, 1); gold_v = 1;
        send(32'd3, 32'd4, 1, 0, 0);

        // random operations with random back-pressure and input gaps
        rand_rdy = 1; rand_gap = 1;
        for (int op = 0; op < 40; op++) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++)
                send(rnd_word(), rnd_word(), (i == len - 1), 1'($urandom), 1'($urandom));
        end

        rand_rdy = 0;
        begin
            int t = 0;
            idle(1);
            while ((sb.size() != 0 || pend_v) && t < 100) begin
                idle(1);
                t++;
            end
            if (sb.size() != 0 || pend_v) begin
                n_cmp++; n_err++;
                $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
            end
        end
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
